// File: rtl/gray_updown_counter_pkg.sv
// Shared Gray-code definitions: direction encodings used by the Gray counters.
package gray_updown_counter_pkg;

    // Direction input encodings
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : gray_updown_counter_pkg

// File: rtl/gray_updown_counter_gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits from the MSB down to that bit.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each bit is its own reduction XOR, so no bit depends on another output bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end

endmodule : gray2bin

// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with a registered Gray output, a binary mirror,
// a Gray-coded synchronous load and wrap-direction flags (sticky or pulsed).
module gray_updown_counter
    import gray_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STICKY = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_val,
    input  logic             Clr_flags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Bin,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Reject widths outside the supported range at elaboration time.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("gray_updown_counter: WIDTH out of range");
    end

    localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;

    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] gray_reg;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             up_wrap;
    logic             down_wrap;
    logic [WIDTH-1:0] load_bin;

    // Load_val arrives Gray-coded; the count itself is kept in binary.
    gray2bin #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray (Load_val),
        .bin  (load_bin)
    );

    // Next count and wrap detection: Load beats En, En beats hold.
    always_comb begin
        b_next    = b_reg;
        up_wrap   = 1'b0;
        down_wrap = 1'b0;
        if (Load) begin
            b_next = load_bin;
        end else if (En) begin
            if (Dir == DIR_UP) begin
                b_next  = b_reg + 1'b1;
                up_wrap = (b_reg == COUNT_MAX);
            end else begin
                b_next    = b_reg - 1'b1;
                down_wrap = (b_reg == COUNT_ZERO);
            end
        end
        wrap_next = up_wrap | down_wrap;
    end

    // Flag update: a fresh wrap always wins over a clear; otherwise sticky flags
    // hold until cleared and pulsed flags drop back to zero.
    always_comb begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (up_wrap) begin
            overflow_next = 1'b1;
        end else if (STICKY != 0 && !Clr_flags) begin
            overflow_next = overflow_reg;
        end
        if (down_wrap) begin
            underflow_next = 1'b1;
        end else if (STICKY != 0 && !Clr_flags) begin
            underflow_next = underflow_reg;
        end
    end

    // State registers; Gray output is encoded from the next count so it lines
    // up with the binary count in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            b_reg         <= '0;
            gray_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            wrap_reg      <= 1'b0;
        end else begin
            b_reg         <= b_next;
            gray_reg      <= b_next ^ (b_next >> 1);
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            wrap_reg      <= wrap_next;
        end
    end

    assign Output    = gray_reg;
    assign Bin       = b_reg;
    assign Overflow  = overflow_reg;
    assign Underflow = underflow_reg;
    assign Wrap      = wrap_reg;

endmodule : gray_updown_counter

// File: tb/tb_gray_updown_counter.sv
// Directed and randomized checks of gray_updown_counter (3-bit sticky,
// 3-bit pulsed and 8-bit instances).
module tb_gray_updown_counter;

    logic       Clk;
    logic       Reset_n;
    logic       En;
    logic       Dir;
    logic       Load;
    logic [2:0] Load_val;
    logic       Clr_flags;

    logic [2:0] out_s, bin_s, out_p, bin_p;
    logic       ov_s, un_s, wr_s, ov_p, un_p, wr_p;

    logic       rst8_n, en8, dir8;
    logic [7:0] out8, bin8;
    logic       ov8, un8, wr8;

    int n_checks = 0;
    int n_fail   = 0;

    gray_updown_counter #(.WIDTH(3), .STICKY(1)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Dir(Dir), .Load(Load),
        .Load_val(Load_val), .Clr_flags(Clr_flags), .Output(out_s), .Bin(bin_s),
        .Overflow(ov_s), .Underflow(un_s), .Wrap(wr_s)
    );

    gray_updown_counter #(.WIDTH(3), .STICKY(0)) dut_p (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Dir(Dir), .Load(Load),
        .Load_val(Load_val), .Clr_flags(Clr_flags), .Output(out_p), .Bin(bin_p),
        .Overflow(ov_p), .Underflow(un_p), .Wrap(wr_p)
    );

    gray_updown_counter #(.WIDTH(8), .STICKY(1)) dut8 (
        .Clk(Clk), .Reset_n(rst8_n), .En(en8), .Dir(dir8), .Load(1'b0),
        .Load_val(8'h00), .Clr_flags(1'b0), .Output(out8), .Bin(bin8),
        .Overflow(ov8), .Underflow(un8), .Wrap(wr8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full check of the sticky instance.
    task automatic chk_s(input string tag, input logic [2:0] g, input logic [2:0] b,
                         input logic ov, input logic un, input logic wr);
        check({tag, ".out"},  {13'd0, out_s}, {13'd0, g});
        check({tag, ".bin"},  {13'd0, bin_s}, {13'd0, b});
        check({tag, ".ov"},   {15'd0, ov_s},  {15'd0, ov});
        check({tag, ".un"},   {15'd0, un_s},  {15'd0, un});
        check({tag, ".wrap"}, {15'd0, wr_s},  {15'd0, wr});
        $display("step %s: out=%b bin=%0d ov=%b un=%b wrap=%b | pulsed ov=%b un=%b",
                 tag, out_s, bin_s, ov_s, un_s, wr_s, ov_p, un_p);
    endtask

    // Flag check of the pulsed instance.
    task automatic chk_p(input string tag, input logic ov, input logic un);
        check({tag, ".p_ov"}, {15'd0, ov_p}, {15'd0, ov});
        check({tag, ".p_un"}, {15'd0, un_p}, {15'd0, un});
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int ones8(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    initial begin
        logic [2:0] up_seq [8];
        logic [7:0] exp_b8;
        logic [7:0] prev_g8;
        logic       exp_wr8;
        logic       exp_ov8;
        logic       exp_un8;

        up_seq[0] = 3'b001; up_seq[1] = 3'b011; up_seq[2] = 3'b010; up_seq[3] = 3'b110;
        up_seq[4] = 3'b111; up_seq[5] = 3'b101; up_seq[6] = 3'b100; up_seq[7] = 3'b000;

        Reset_n = 1'b1; rst8_n = 1'b1;
        En = 1'b0; Dir = 1'b1; Load = 1'b0; Load_val = 3'b000; Clr_flags = 1'b0;
        en8 = 1'b0; dir8 = 1'b0;
        #1;
        Reset_n = 1'b0; rst8_n = 1'b0;
        #1;
        chk_s("reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_p("reset", 1'b0, 1'b0);
        check("reset8.out", {8'd0, out8}, 16'd0);

        // Enable while still in reset: edges must not count.
        En = 1'b1; Dir = 1'b1;
        tick();
        chk_s("held_in_reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Eight up steps through the wrap.
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_s($sformatf("up%0d", i), up_seq[i], 3'(i + 1),
                  (i == 7), 1'b0, (i == 7));
            chk_p($sformatf("up%0d", i), (i == 7), 1'b0);
        end

        // Hold: Wrap drops, sticky overflow stays, pulsed overflow drops.
        En = 1'b0;
        tick();
        chk_s("hold", 3'b000, 3'd0, 1'b1, 1'b0, 1'b0);
        chk_p("hold", 1'b0, 1'b0);

        // Clear together with a down-wrap: underflow wins, overflow clears.
        En = 1'b1; Dir = 1'b0; Clr_flags = 1'b1;
        tick();
        chk_s("clr_dnwrap", 3'b100, 3'd7, 1'b0, 1'b1, 1'b1);
        chk_p("clr_dnwrap", 1'b0, 1'b1);

        // Load ignores En/Dir and leaves the sticky flag alone.
        Clr_flags = 1'b0; Load = 1'b1; Load_val = 3'b110; En = 1'b1; Dir = 1'b1;
        tick();
        chk_s("load", 3'b110, 3'd4, 1'b0, 1'b1, 1'b0);
        chk_p("load", 1'b0, 1'b0);

        Load = 1'b0;
        tick();
        chk_s("after_load", 3'b111, 3'd5, 1'b0, 1'b1, 1'b0);

        // Clr_flags alone: flags go, count stays.
        En = 1'b0; Clr_flags = 1'b1;
        tick();
        chk_s("clr_only", 3'b111, 3'd5, 1'b0, 1'b0, 1'b0);
        Clr_flags = 1'b0;

        // Asynchronous reset between edges at Output=111.
        #2;
        Reset_n = 1'b0;
        #1;
        chk_s("async_rst", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1; En = 1'b1; Dir = 1'b1;
        tick();
        chk_s("resume", 3'b001, 3'd1, 1'b0, 1'b0, 1'b0);

        // From reset, count down twice, then reverse direction immediately.
        @(negedge Clk);
        Reset_n = 1'b0;
        Dir = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        chk_s("dn0", 3'b100, 3'd7, 1'b0, 1'b1, 1'b1);
        chk_p("dn0", 1'b0, 1'b1);
        tick();
        chk_s("dn1", 3'b101, 3'd6, 1'b0, 1'b1, 1'b0);
        chk_p("dn1", 1'b0, 1'b0);
        Dir = 1'b1;
        tick();
        chk_s("dir_flip", 3'b100, 3'd7, 1'b0, 1'b1, 1'b0);

        // 8-bit random walk against a binary reference count.
        @(negedge Clk);
        rst8_n = 1'b1;
        exp_b8 = 8'd0; exp_ov8 = 1'b0; exp_un8 = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            en8  = 1'($urandom_range(0, 1));
            dir8 = 1'($urandom_range(0, 1));
            prev_g8 = out8;
            exp_wr8 = 1'b0;
            if (en8) begin
                if (dir8) begin
                    if (exp_b8 == 8'hFF) begin exp_wr8 = 1'b1; exp_ov8 = 1'b1; end
                    exp_b8 = exp_b8 + 8'd1;
                end else begin
                    if (exp_b8 == 8'h00) begin exp_wr8 = 1'b1; exp_un8 = 1'b1; end
                    exp_b8 = exp_b8 - 8'd1;
                end
            end
            tick();
            check("w8.bin",      {8'd0, bin8},       {8'd0, exp_b8});
            check("w8.g2b",      {8'd0, g2b8(out8)}, {8'd0, bin8});
            check("w8.onebit",   16'(ones8(prev_g8 ^ out8)), 16'(en8 ? 1 : 0));
            check("w8.wrap",     {15'd0, wr8},       {15'd0, exp_wr8});
            check("w8.flags",    {14'd0, ov8, un8},  {14'd0, exp_ov8, exp_un8});
        end
        $display("random walk: 10000 cycles, final bin=%0d out=%b", bin8, out8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gray_updown_counter
